mem_arbiter: RTL and testbench

Single-port memory arbiter between the CPU's instruction-fetch and data-access ports and the unified byte-addressed SRAM (`memory`) inside `Top`. Accepts one word request per port, serialises them onto one memory port with a fixed access latency, and generates the `inst_mem_stall` / `data_mem_stall` signals the CPU pipeline freezes on. Sits between `cpu` and `memory` in `Top`.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: FSM encoding and word/byte-enable widths.
// Imported by mem_arbiter and arb_pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Round-robin pick between fetch and data ports; fetch wins the first tie
// after reset. Unused when MEM_ARB_DATA_PRIO_EN is defined.
import mem_arbiter_pkg::*;

module arb_pick (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic gnt,
  input  logic gnt_d,
  output logic pick_d
);

  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (gnt) begin
      last_d <= gnt_d;
    end
  end

  assign pick_d = d_req && (!i_req || !last_d);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data ports with fixed latency.
// MEM_ARB_DATA_PRIO_EN: data port wins ties; otherwise round-robin.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam bit         LAT1     = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  arb_state_t state, state_n;

  logic [3:0]        cnt;
  logic              fwd, fwd_d;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] wdata_q, i_q, d_q;
  logic              pick_d, gnt, gnt_d;
  logic              busy_done, done_i, done_d, ld_done;

`ifdef MEM_ARB_DATA_PRIO_EN
  assign pick_d = d_req;
`else
  arb_pick u_pick (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .d_req  (d_req),
    .gnt    (gnt),
    .gnt_d  (gnt_d),
    .pick_d (pick_d)
  );
`endif

  // cnt counts down to the done cycle: done when it is about to hit zero
  assign busy_done = (state != ARB_IDLE) && (cnt == 4'd1);

  always_comb begin
    gnt     = 1'b0;
    gnt_d   = 1'b0;
    state_n = state;
    case (state)
      ARB_IDLE: begin
        if (fwd) begin
          gnt   = fwd_d ? d_req : i_req;
          gnt_d = fwd_d;
        end else begin
          gnt   = i_req || d_req;
          gnt_d = pick_d;
        end
        if (rst) gnt = 1'b0;
      end
      ARB_BUSY_I,
      ARB_BUSY_D: begin
        if (busy_done) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
    if (gnt && !LAT1) begin
      state_n = gnt_d ? ARB_BUSY_D : ARB_BUSY_I;
    end
  end

  assign done_i = ((state == ARB_BUSY_I) && busy_done)
               || (LAT1 && gnt && !gnt_d);
  assign done_d = ((state == ARB_BUSY_D) && busy_done)
               || (LAT1 && gnt && gnt_d);
  assign ld_done = done_d && !(LAT1 ? d_we : we_q);

  assign i_stall = i_req && !done_i;
  assign d_stall = d_req && !done_d;
  assign i_rdata = done_i  ? m_rdata : i_q;
  assign d_rdata = ld_done ? m_rdata : d_q;

  assign sel_addr = gnt_d ? d_addr : i_addr;
  assign m_en     = gnt;
  assign m_we     = gnt ? (gnt_d && d_we) : we_q;
  assign m_be     = gnt ? (gnt_d ? d_be : 4'hF) : be_q;
  assign m_addr   = gnt ? {sel_addr[ADDR_W-1:2], 2'b00} : addr_q;
  assign m_wdata  = gnt ? d_wdata : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      cnt     <= 4'd0;
      fwd     <= 1'b0;
      fwd_d   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      i_q     <= '0;
      d_q     <= '0;
    end else begin
      state <= state_n;
      if (gnt) begin
        cnt     <= CNT_INIT;
        addr_q  <= m_addr;
        we_q    <= m_we;
        be_q    <= m_be;
        wdata_q <= m_wdata;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done_i)  i_q <= m_rdata;
      if (ld_done) d_q <= m_rdata;
      // hand the port straight to a waiting peer on the next cycle
      fwd   <= (done_i && d_req) || (done_d && i_req);
      fwd_d <= done_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=2 instance plus a LATENCY=1
// instance for back-to-back fetches.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

`ifdef MEM_ARB_DATA_PRIO_EN
  localparam int RI = 3;
  localparam int RD = 1;
`else
  localparam int RI = 1;
  localparam int RD = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, m_addr;
  logic [3:0]  d_be, m_be;
  logic [31:0] d_wdata, i_rdata, d_rdata, m_wdata, rd2;
  logic        i_stall, d_stall, m_en, m_we;

  logic        l1_i_req, l1_i_stall, l1_d_stall, l1_m_en, l1_m_we;
  logic [15:0] l1_i_addr, l1_m_addr;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_m_wdata, l1_m_rdata;
  logic [3:0]  l1_m_be;
  logic [31:0] l1_exp [3];

  logic [7:0] mem [0:65535];
  exp_t qi[$];
  exp_t qd[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(16), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(rd2)
  );

  mem_arbiter #(.ADDR_W(16), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata),
    .i_stall(l1_i_stall),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(16'h0),
    .d_wdata(32'h0), .d_rdata(l1_d_rdata), .d_stall(l1_d_stall),
    .m_en(l1_m_en), .m_we(l1_m_we), .m_be(l1_m_be), .m_addr(l1_m_addr),
    .m_wdata(l1_m_wdata), .m_rdata(l1_m_rdata)
  );

  // registered-read memory for the LATENCY=2 instance
  always @(posedge clk) begin
    if (m_en) begin
      rd2 <= {mem[m_addr + 16'd3], mem[m_addr + 16'd2],
              mem[m_addr + 16'd1], mem[m_addr]};
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr + 16'(b)] <= m_wdata[8*b +: 8];
      end
    end
  end

  assign l1_m_rdata = {mem[l1_m_addr + 16'd3], mem[l1_m_addr + 16'd2],
                       mem[l1_m_addr + 16'd1], mem[l1_m_addr]};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (i_req && !i_stall) begin
        if (qi.size() == 0) begin
          check("i_unexpected_done", 32'(i_stall), 32'd1);
        end else begin
          e = qi.pop_front();
          check("i_rdata", i_rdata, e.data);
          check("i_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (d_req && !d_stall) begin
        if (qd.size() == 0) begin
          check("d_unexpected_done", 32'(d_stall), 32'd1);
        end else begin
          e = qd.pop_front();
          check("d_rdata", d_rdata, e.data);
          check("d_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic put(input logic [15:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem[a + 16'(b)] = w[8*b +: 8];
  endtask

  task automatic do_i(input logic [15:0] a, input logic [15:0] ea,
                      input logic [31:0] exp, input int rel, input bit chk);
    qi.push_back('{exp, cyc + rel});
    i_req = 1'b1;
    i_addr = a;
    @(negedge clk);
    if (chk) begin
      check("i_grant_m_en", 32'(m_en), 32'd1);
      check("i_grant_m_addr", 32'(m_addr), 32'(ea));
      check("i_grant_stall", 32'(i_stall), 32'd1);
    end
    for (int k = 0; k < 16 && i_stall; k++) @(negedge clk);
    if (i_stall) check("i_timeout", 32'(i_stall), 32'd0);
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic do_d(input logic [15:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [15:0] ea, input logic [31:0] exp,
                      input int rel, input bit chk);
    qd.push_back('{exp, cyc + rel});
    d_req = 1'b1;
    d_addr = a;
    d_we = we;
    d_be = be;
    d_wdata = wd;
    @(negedge clk);
    if (chk) begin
      check("d_grant_m_en", 32'(m_en), 32'd1);
      check("d_grant_m_addr", 32'(m_addr), 32'(ea));
      check("d_grant_m_we", 32'(m_we), 32'(we));
      check("d_grant_stall", 32'(d_stall), 32'd1);
      if (we) check("d_grant_m_be", 32'(m_be), 32'(be));
    end
    for (int k = 0; k < 16 && d_stall; k++) @(negedge clk);
    if (d_stall) check("d_timeout", 32'(d_stall), 32'd0);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    put(16'h0000, 32'h11223344);
    put(16'h0004, 32'h00500093);
    put(16'h0008, 32'hCAFEF00D);
    l1_exp[0] = 32'h11223344;
    l1_exp[1] = 32'h00500093;
    l1_exp[2] = 32'hCAFEF00D;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
    d_be = 0; d_addr = 0; d_wdata = 0;
    l1_i_req = 0; l1_i_addr = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_i_stall", 32'(i_stall), 32'd0);
    check("rst_d_stall", 32'(d_stall), 32'd0);
    check("rst_m_en", 32'(m_en), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_l1_m_en", 32'(l1_m_en), 32'd0);
    @(posedge clk);
    #1;

    do_i(16'h0004, 16'h0004, 32'h00500093, 1, 1'b1);
    do_i(16'h0007, 16'h0004, 32'h00500093, 1, 1'b1);
    do_d(16'h8002, 1'b1, 4'b1100, 32'hAABBCCDD, 16'h8000, 32'h0, 1, 1'b1);
    check("mem_8000_after_store",
          {mem[16'h8003], mem[16'h8002], mem[16'h8001], mem[16'h8000]},
          32'hAABB0000);
    do_d(16'h8000, 1'b0, 4'hF, 32'h0, 16'h8000, 32'hAABB0000, 1, 1'b1);

    // load aborted by reset in its done cycle
    d_req = 1'b1; d_addr = 16'h8000; d_we = 1'b0; d_be = 4'hF;
    @(posedge clk);
    #1 rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_m_en", 32'(m_en), 32'd0);
    check("abort_d_stall", 32'(d_stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_d(16'h8000, 1'b0, 4'hF, 32'h0, 16'h8000, 32'hAABB0000, 1, 1'b1);

    for (int t = 0; t < 2; t++) begin
      fork
        do_i(16'h0000, 16'h0000, 32'h11223344, RI, 1'b0);
        do_d(16'h8000, 1'b0, 4'hF, 32'h0, 16'h8000, 32'hAABB0000, RD, 1'b0);
      join
    end

    l1_i_req = 1'b1;
    l1_i_addr = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("l1_i_stall", 32'(l1_i_stall), 32'd0);
      check("l1_m_en", 32'(l1_m_en), 32'd1);
      check("l1_m_addr", 32'(l1_m_addr), 32'(k * 4));
      check("l1_i_rdata", l1_i_rdata, l1_exp[k]);
      @(posedge clk);
      #1 l1_i_addr = 16'((k + 1) * 4);
    end
    l1_i_req = 1'b0;

    repeat (4) @(posedge clk);
    check("qi_drained", 32'(qi.size()), 32'd0);
    check("qd_drained", 32'(qd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
